// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - shared types and constants for the access-code lock
package code_lock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int QUEUE_DEPTH = 4;
    localparam int WINDOW_W    = BYTE_W * QUEUE_DEPTH;

    localparam logic [WINDOW_W-1:0] DEFAULT_CODE = 32'h01020304;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// rtl/rise_edge_det.sv - registered-history rising-edge detector for a level input
module rise_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic EDGE
);

    logic prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev <= 1'b0;
        end else begin
            prev <= IN;
        end
    end

    assign EDGE = IN && !prev;

endmodule

// File: rtl/code_checker.sv
// rtl/code_checker.sv - compares the byte-queue window against the stored code on CHECK
module code_checker
    import code_lock_pkg::*;
#(
    parameter logic [WINDOW_W-1:0] CODE        = DEFAULT_CODE,
    parameter int                  MAX_FAILS   = 3,
    parameter int                  OPEN_CYCLES = 8,
    parameter int                  LOCK_CYCLES = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             ENA,
    input  logic                             CHECK,
    input  logic [WINDOW_W-1:0]              QUEUE_DATA,
    output logic                             OPEN,
    output logic                             ERROR,
    output logic                             LOCKED,
    output logic [2:0]                       ENTRY_CNT,
    output logic [$clog2(MAX_FAILS+1)-1:0]   FAIL_CNT
);

    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TIMER_W = $clog2(max_int(OPEN_CYCLES, LOCK_CYCLES) + 1);
    localparam logic [2:0] ENTRY_MAX = 3'(QUEUE_DEPTH);

    if (MAX_FAILS < 1 || OPEN_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_bad_params
        $error("code_checker: MAX_FAILS, OPEN_CYCLES and LOCK_CYCLES must be >= 1");
    end

    logic ena_edge;
    logic check_edge;

    rise_edge_det u_ena_edge (
        .CLK  (CLK),
        .RST  (RST),
        .IN   (ENA),
        .EDGE (ena_edge)
    );

    rise_edge_det u_check_edge (
        .CLK  (CLK),
        .RST  (RST),
        .IN   (CHECK),
        .EDGE (check_edge)
    );

    state_t              state_q;
    state_t              state_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic                open_d;
    logic                error_d;
    logic                locked_d;
    logic [2:0]          entry_d;
    logic [FAIL_W-1:0]   fail_d;
    logic [FAIL_W-1:0]   fail_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            OPEN      <= 1'b0;
            ERROR     <= 1'b0;
            LOCKED    <= 1'b0;
            ENTRY_CNT <= '0;
            FAIL_CNT  <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            OPEN      <= open_d;
            ERROR     <= error_d;
            LOCKED    <= locked_d;
            ENTRY_CNT <= entry_d;
            FAIL_CNT  <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        open_d   = OPEN;
        error_d  = 1'b0;
        locked_d = LOCKED;
        entry_d  = ENTRY_CNT;
        fail_d   = FAIL_CNT;
        fail_inc = FAIL_CNT + FAIL_W'(1);

        case (state_q)
            IDLE: begin
                // CHECK takes priority over a simultaneous ENA: the window seen
                // here is still the pre-shift one, and that entry is discarded.
                if (check_edge) begin
                    entry_d = '0;
                    if (ENTRY_CNT == ENTRY_MAX && QUEUE_DATA == CODE) begin
                        state_d = UNLOCKED;
                        timer_d = TIMER_W'(OPEN_CYCLES);
                        open_d  = 1'b1;
                        fail_d  = '0;
                    end else begin
                        error_d = 1'b1;
                        fail_d  = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d  = LOCKOUT;
                            timer_d  = TIMER_W'(LOCK_CYCLES);
                            locked_d = 1'b1;
                        end
                    end
                end else if (ena_edge && ENTRY_CNT != ENTRY_MAX) begin
                    entry_d = ENTRY_CNT + 3'd1;
                end
            end

            UNLOCKED: begin
                entry_d = '0;
                if (timer_q <= TIMER_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    open_d  = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            LOCKOUT: begin
                entry_d = '0;
                if (timer_q <= TIMER_W'(1)) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    locked_d = 1'b0;
                    fail_d   = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                open_d   = 1'b0;
                locked_d = 1'b0;
                entry_d  = '0;
                fail_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_code_checker.sv
// tb/tb_code_checker.sv - directed self-checking bench for code_checker with a byte queue model
module tb_code_checker;

    logic        CLK;
    logic        RST;
    logic        ENA;
    logic        CHECK;
    logic [31:0] q;
    logic        OPEN;
    logic        ERROR;
    logic        LOCKED;
    logic [2:0]  ENTRY_CNT;
    logic [1:0]  FAIL_CNT;

    logic [7:0]  byte_in;
    logic        q_prev;

    int checks = 0;
    int errors = 0;

    code_checker dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENA        (ENA),
        .CHECK      (CHECK),
        .QUEUE_DATA (q),
        .OPEN       (OPEN),
        .ERROR      (ERROR),
        .LOCKED     (LOCKED),
        .ENTRY_CNT  (ENTRY_CNT),
        .FAIL_CNT   (FAIL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Upstream 4-stage byte queue: shifts on the ENA rising edge, never cleared.
    initial q = 32'h0;
    always @(posedge CLK or posedge RST) begin
        if (RST) q_prev <= 1'b0;
        else     q_prev <= ENA;
    end
    always @(posedge CLK) begin
        if (ENA && !q_prev) q <= {q[23:0], byte_in};
    end

    task automatic enter_byte(input logic [7:0] b);
        byte_in = b;
        ENA = 1'b1;
        @(negedge CLK);
        ENA = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_check();
        CHECK = 1'b1;
        @(negedge CLK);
        CHECK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; ENA = 1'b0; CHECK = 1'b0; byte_in = 8'h00;
        repeat (3) @(negedge CLK);
        checks++; if (OPEN !== 1'b0)      begin errors++; $display("FAIL reset_open: got %b expected 0", OPEN); end
        checks++; if (ERROR !== 1'b0)     begin errors++; $display("FAIL reset_error: got %b expected 0", ERROR); end
        checks++; if (LOCKED !== 1'b0)    begin errors++; $display("FAIL reset_locked: got %b expected 0", LOCKED); end
        checks++; if (ENTRY_CNT !== 3'd0) begin errors++; $display("FAIL reset_entry: got %0d expected 0", ENTRY_CNT); end
        checks++; if (FAIL_CNT !== 2'd0)  begin errors++; $display("FAIL reset_fail: got %0d expected 0", FAIL_CNT); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_unlock();
        int n;
        enter_byte(8'h01); enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h04);
        checks++; if (ENTRY_CNT !== 3'd4) begin errors++; $display("FAIL unlock_entry4: got %0d expected 4", ENTRY_CNT); end
        do_check();
        checks++; if (OPEN !== 1'b1)      begin errors++; $display("FAIL unlock_open: got %b expected 1", OPEN); end
        checks++; if (ERROR !== 1'b0)     begin errors++; $display("FAIL unlock_error: got %b expected 0", ERROR); end
        checks++; if (ENTRY_CNT !== 3'd0) begin errors++; $display("FAIL unlock_entry0: got %0d expected 0", ENTRY_CNT); end
        checks++; if (FAIL_CNT !== 2'd0)  begin errors++; $display("FAIL unlock_fail: got %0d expected 0", FAIL_CNT); end
        n = 0;
        while (OPEN === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        checks++; if (n !== 8) begin errors++; $display("FAIL unlock_open_len: got %0d cycles expected 8", n); end
    endtask

    task automatic test_wrong_and_lockout();
        int n;
        enter_byte(8'h01); enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h05);
        do_check();
        checks++; if (ERROR !== 1'b1)    begin errors++; $display("FAIL wrong1_error: got %b expected 1", ERROR); end
        checks++; if (FAIL_CNT !== 2'd1) begin errors++; $display("FAIL wrong1_fail: got %0d expected 1", FAIL_CNT); end
        checks++; if (OPEN !== 1'b0)     begin errors++; $display("FAIL wrong1_open: got %b expected 0", OPEN); end
        @(negedge CLK);
        checks++; if (ERROR !== 1'b0)    begin errors++; $display("FAIL wrong1_error_pulse: got %b expected 0", ERROR); end
        enter_byte(8'h05); enter_byte(8'h05); enter_byte(8'h05); enter_byte(8'h05);
        do_check();
        checks++; if (FAIL_CNT !== 2'd2) begin errors++; $display("FAIL wrong2_fail: got %0d expected 2", FAIL_CNT); end
        checks++; if (LOCKED !== 1'b0)   begin errors++; $display("FAIL wrong2_locked: got %b expected 0", LOCKED); end
        @(negedge CLK);
        enter_byte(8'h01); enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h06);
        do_check();
        checks++; if (ERROR !== 1'b1)    begin errors++; $display("FAIL wrong3_error: got %b expected 1", ERROR); end
        checks++; if (LOCKED !== 1'b1)   begin errors++; $display("FAIL wrong3_locked: got %b expected 1", LOCKED); end
        checks++; if (FAIL_CNT !== 2'd3) begin errors++; $display("FAIL wrong3_fail: got %0d expected 3", FAIL_CNT); end
        n = 0;
        while (LOCKED === 1'b1 && n < 60) begin n++; @(negedge CLK); end
        checks++; if (n !== 16)          begin errors++; $display("FAIL lock_len: got %0d cycles expected 16", n); end
        checks++; if (FAIL_CNT !== 2'd0) begin errors++; $display("FAIL lock_exit_fail: got %0d expected 0", FAIL_CNT); end
    endtask

    task automatic test_stale_window();
        enter_byte(8'h01);
        do_check();
        checks++; if (ERROR !== 1'b1)    begin errors++; $display("FAIL short_error: got %b expected 1", ERROR); end
        checks++; if (FAIL_CNT !== 2'd1) begin errors++; $display("FAIL short_fail: got %0d expected 1", FAIL_CNT); end
        @(negedge CLK);
        enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h04);
        checks++; if (ENTRY_CNT !== 3'd3) begin errors++; $display("FAIL stale_entry: got %0d expected 3", ENTRY_CNT); end
        do_check();
        checks++; if (ERROR !== 1'b1)    begin errors++; $display("FAIL stale_error: got %b expected 1", ERROR); end
        checks++; if (OPEN !== 1'b0)     begin errors++; $display("FAIL stale_open: got %b expected 0", OPEN); end
        checks++; if (FAIL_CNT !== 2'd2) begin errors++; $display("FAIL stale_fail: got %0d expected 2", FAIL_CNT); end
        @(negedge CLK);
    endtask

    task automatic test_same_cycle();
        int n;
        enter_byte(8'h09); enter_byte(8'h01); enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h04);
        checks++; if (ENTRY_CNT !== 3'd4) begin errors++; $display("FAIL entry_saturate: got %0d expected 4", ENTRY_CNT); end
        byte_in = 8'h09;
        ENA = 1'b1;
        CHECK = 1'b1;
        @(negedge CLK);
        ENA = 1'b0;
        CHECK = 1'b0;
        checks++; if (OPEN !== 1'b1)      begin errors++; $display("FAIL both_open: got %b expected 1", OPEN); end
        checks++; if (ERROR !== 1'b0)     begin errors++; $display("FAIL both_error: got %b expected 0", ERROR); end
        checks++; if (ENTRY_CNT !== 3'd0) begin errors++; $display("FAIL both_entry: got %0d expected 0", ENTRY_CNT); end
        checks++; if (FAIL_CNT !== 2'd0)  begin errors++; $display("FAIL both_fail: got %0d expected 0", FAIL_CNT); end
        n = 0;
        while (OPEN === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        checks++; if (n !== 8)            begin errors++; $display("FAIL both_open_len: got %0d cycles expected 8", n); end
        checks++; if (ENTRY_CNT !== 3'd0) begin errors++; $display("FAIL both_entry_after: got %0d expected 0", ENTRY_CNT); end
    endtask

    task automatic test_lockout_ignore();
        int n;
        do_check(); @(negedge CLK);
        do_check(); @(negedge CLK);
        do_check();
        checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL ign_locked: got %b expected 1", LOCKED); end
        for (int i = 0; i < 6; i++) begin
            ENA   = (i % 2 == 0);
            CHECK = (i % 2 == 0);
            @(negedge CLK);
            checks++; if (ERROR !== 1'b0 || OPEN !== 1'b0 || ENTRY_CNT !== 3'd0 || LOCKED !== 1'b1) begin
                errors++;
                $display("FAIL ign_cycle%0d: got err=%b open=%b entry=%0d locked=%b expected 0 0 0 1",
                         i, ERROR, OPEN, ENTRY_CNT, LOCKED);
            end
        end
        CHECK = 1'b1;
        n = 0;
        while (LOCKED === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL hold_exit: got locked=%b expected 0", LOCKED); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (ERROR !== 1'b0 || OPEN !== 1'b0 || FAIL_CNT !== 2'd0) begin
                errors++;
                $display("FAIL hold_nofire%0d: got err=%b open=%b fail=%0d expected 0 0 0",
                         i, ERROR, OPEN, FAIL_CNT);
            end
        end
        CHECK = 1'b0;
        @(negedge CLK);
        do_check();
        checks++; if (ERROR !== 1'b1)    begin errors++; $display("FAIL rearm_error: got %b expected 1", ERROR); end
        checks++; if (FAIL_CNT !== 2'd1) begin errors++; $display("FAIL rearm_fail: got %0d expected 1", FAIL_CNT); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int n;
        enter_byte(8'h01); enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h04);
        do_check();
        checks++; if (OPEN !== 1'b1) begin errors++; $display("FAIL rmid_open: got %b expected 1", OPEN); end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (OPEN !== 1'b0 || LOCKED !== 1'b0 || ERROR !== 1'b0 || ENTRY_CNT !== 3'd0 || FAIL_CNT !== 2'd0) begin
            errors++;
            $display("FAIL rmid_async: got open=%b locked=%b err=%b entry=%0d fail=%0d expected all 0",
                     OPEN, LOCKED, ERROR, ENTRY_CNT, FAIL_CNT);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        enter_byte(8'h01); enter_byte(8'h02); enter_byte(8'h03); enter_byte(8'h04);
        do_check();
        checks++; if (OPEN !== 1'b1) begin errors++; $display("FAIL rmid_reopen: got %b expected 1", OPEN); end
        n = 0;
        while (OPEN === 1'b1 && n < 40) begin n++; @(negedge CLK); end
        checks++; if (n !== 8) begin errors++; $display("FAIL rmid_open_len: got %0d cycles expected 8", n); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_wrong_and_lockout();
        test_stale_window();
        test_same_cycle();
        test_lockout_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/code_checker.md
# code_checker

Access-code checker sitting directly downstream of the 4-stage byte queue. It consumes the queue's 32-bit window of the last four entered bytes (oldest in bits 31:24) plus the same ENA strobe that loads the queue, and decides on a user CHECK request whether the window matches the stored code. It drives the unlock pulse, a per-attempt error pulse and a timed lockout after repeated failures.

## Interface
Parameters:
- CODE, 32'h01020304, expected window value, oldest byte in [31:24]
- MAX_FAILS, 3, consecutive failed checks that trigger lockout (≥1)
- OPEN_CYCLES, 8, cycles OPEN stays high after a match (≥1)
- LOCK_CYCLES, 16, cycles LOCKED stays high (≥1)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- ENA  in  1  level entry strobe, same signal driving the queue's ENA
- CHECK  in  1  level check request
- QUEUE_DATA  in  32  queue DATAOUT
- OPEN  out  1  unlock, high for OPEN_CYCLES
- ERROR  out  1  one-cycle pulse per failed check
- LOCKED  out  1  lockout active
- ENTRY_CNT  out  3  fresh entries since last check, saturates at 4
- FAIL_CNT  out  $clog2(MAX_FAILS+1)  consecutive failures

## Operation
- Rising edges of ENA and CHECK detected internally: edge = level && !prev, prev registered, reset to 0. Prev registers update in every state.
- States: IDLE, UNLOCKED, LOCKOUT. Reset → IDLE, all outputs 0, timer 0.
- IDLE:
  - ENA edge, no CHECK edge: ENTRY_CNT += 1, saturating at 4.
  - CHECK edge:
    - Match (ENTRY_CNT==4 and QUEUE_DATA==CODE): → UNLOCKED, load timer OPEN_CYCLES, FAIL_CNT←0, ENTRY_CNT←0.
    - Otherwise (includes fewer than 4 entries): ERROR pulse, ENTRY_CNT←0, FAIL_CNT+1.
    - If FAIL_CNT+1 == MAX_FAILS: → LOCKOUT, load timer LOCK_CYCLES, FAIL_CNT shows MAX_FAILS.
  - ENA and CHECK edges in the same cycle: CHECK wins. The comparison uses the pre-shift QUEUE_DATA, and the ENA edge is not counted (ENTRY_CNT←0).
- UNLOCKED: OPEN=1. Timer decrements each cycle. The cycle it would reach 0 → IDLE, OPEN←0. ENA/CHECK edges ignored, ENTRY_CNT held at 0.
- LOCKOUT: LOCKED=1. Same timer behaviour. On exit → IDLE, LOCKED←0, FAIL_CNT←0. ENA/CHECK edges ignored.
- Queue contents are never cleared by this block. ENTRY_CNT guarantees four fresh bytes per attempt.
- Timer width: $clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1).

## Timing
- All outputs registered. No combinational input→output path.
- ENA edge sampled at clock edge k: the queue shifts and ENTRY_CNT increments at the same edge k, visible after k.
- CHECK edge sampled at edge k, with QUEUE_DATA compared as held before k:
  - OPEN, or ERROR, is high after k.
  - ERROR lasts exactly one cycle.
  - OPEN lasts exactly OPEN_CYCLES cycles.
- Final failure: ERROR and LOCKED both rise after the same edge k. LOCKED lasts exactly LOCK_CYCLES cycles.
- First CHECK edge accepted: the cycle after OPEN/LOCKED falls. A CHECK held high across the exit produces no new edge.
- Reset asserted mid-operation: all state and outputs go to 0 immediately, asynchronously.

## Structure
- Shared package code_lock_pkg holds:
  - state enum (IDLE/UNLOCKED/LOCKOUT)
  - DEFAULT_CODE
  - byte width (8) and queue depth (4) constants; ENTRY_CNT saturates at depth.
- Sub-module rise_edge_det (CLK, RST, IN, EDGE), instantiated for ENA and CHECK. The queue reuses the same cell in future cleanup.
- Single FSM, one shared down-counter timer.

## Test plan
- Reset, then enter 01,02,03,04 via ENA edges with the queue attached, then CHECK edge → QUEUE_DATA=32'h01020304, OPEN high exactly 8 cycles, FAIL_CNT=0, ENTRY_CNT=0.
- Enter 01,02,03,05, then CHECK → ERROR 1 cycle, FAIL_CNT=1, OPEN stays 0. Three wrong attempts → on the third, ERROR and LOCKED rise together. LOCKED high 16 cycles, then FAIL_CNT=0.
- Enter only 02,03,04 (correct tail, window 00020304 or stale), then CHECK → ERROR, even if the window equals CODE from a previous session (ENTRY_CNT=3).
- ENA and CHECK rise in the same cycle after 4 correct entries → compare uses pre-shift 01020304 → OPEN. ENTRY_CNT=0.
- During LOCKOUT, toggle ENA and CHECK → no ERROR/OPEN, ENTRY_CNT stays 0. Hold CHECK high through the exit → no check fires until CHECK drops and rises again.
- Assert RST in cycle 3 of UNLOCKED → OPEN, LOCKED, ERROR, ENTRY_CNT, FAIL_CNT all 0 immediately. After release, a correct 4-entry sequence unlocks again.
